// File: rtl/bus_pkg.sv
// Shared types and helpers for the N-slave bus arbiter and its address decoder.
package bus_pkg;

   // Transfer engine states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_state_t;

   // Read data returned on an error response unless the top is told otherwise.
   localparam logic [31:0] ERRDATA_DEFAULT = 32'hDEADBEEF;

   // Width of the slave-select field: clog2(nslave), never less than one bit.
   function automatic int sel_bits(input int nslave);
      int b;
      b = $clog2(nslave);
      return (b < 1) ? 1 : b;
   endfunction

endpackage

// File: rtl/bus_decoder.sv
// Combinational address decoder: splits a master byte address into a slave
// index and a mapped flag. Each slave owns a 2**REGIONBITS byte region
// starting at address zero; anything beyond the last slave is unmapped.
module bus_decoder
   import bus_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NSLAVE     = 4,
   parameter int REGIONBITS = 20,
   parameter int SELBITS    = sel_bits(NSLAVE)
)(
   input  logic [WIDTH-1:0]   maddr,
   output logic [SELBITS-1:0] idx,
   output logic               mapped
);

   logic [SELBITS-1:0] idx_raw;
   logic               upper_zero;
   logic               idx_in_range;
   logic               unused_low;

   assign idx_raw    = maddr[REGIONBITS +: SELBITS];
   // The slave-local offset is not part of the decode.
   assign unused_low = ^maddr[REGIONBITS-1:0];

   generate
      // Bits above the select field must all be zero for a mapped address.
      if (REGIONBITS + SELBITS < WIDTH) begin : g_upper
         assign upper_zero = (maddr[WIDTH-1:REGIONBITS+SELBITS] == '0);
      end else begin : g_no_upper
         assign upper_zero = 1'b1;
      end

      // When NSLAVE fills the select field every index is a real slave.
      if (NSLAVE == (1 << SELBITS)) begin : g_full
         assign idx_in_range = 1'b1;
      end else begin : g_partial
         assign idx_in_range = (idx_raw < SELBITS'(NSLAVE));
      end
   endgenerate

   assign idx    = idx_raw;
   assign mapped = upper_zero & idx_in_range;

endmodule

// File: rtl/bus_arbiter_nslave.sv
// Registered, handshaked data-bus engine connecting one master port to
// NSLAVE memory-mapped slaves. Unmapped addresses answer with an error.
// Optional build macro BUS_TIMEOUT_EN: abort an ACCESS with an error response
// after TIMEOUT cycles without sready; otherwise ACCESS waits indefinitely.
module bus_arbiter_nslave
   import bus_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               NSLAVE     = 4,
   parameter int               REGIONBITS = 20,
   parameter int               TIMEOUT    = 16,
   parameter logic [WIDTH-1:0] ERRDATA    = WIDTH'(ERRDATA_DEFAULT)
)(
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     mreq,
   input  logic                     mwrite,
   input  logic [WIDTH-1:0]         maddr,
   input  logic [WIDTH-1:0]         mwdata,
   output logic [WIDTH-1:0]         mrdata,
   output logic                     mready,
   output logic                     merr,
   output logic [NSLAVE-1:0]        sreq,
   output logic                     swrite,
   output logic [WIDTH-1:0]         saddr,
   output logic [WIDTH-1:0]         swdata,
   input  logic [NSLAVE*WIDTH-1:0]  srdata,
   input  logic [NSLAVE-1:0]        sready,
   output logic [7:0]               errcount
);

   localparam int SELBITS = sel_bits(NSLAVE);

   bus_state_t         state_q, state_d;
   logic [SELBITS-1:0] idx_q, idx_d;
   logic [NSLAVE-1:0]  sreq_q, sreq_d;
   logic               swrite_q, swrite_d;
   logic [WIDTH-1:0]   saddr_q, saddr_d;
   logic [WIDTH-1:0]   swdata_q, swdata_d;
   logic [WIDTH-1:0]   mrdata_q, mrdata_d;
   logic               mready_q, mready_d;
   logic               merr_q, merr_d;
   logic [7:0]         errcount_q, errcount_d;

   logic [SELBITS-1:0] dec_idx;
   logic               dec_mapped;
   logic [NSLAVE-1:0]  dec_onehot;
   logic [WIDTH-1:0]   local_addr;
   logic [WIDTH-1:0]   srdata_arr [NSLAVE];
   logic               sel_ready;
   logic [WIDTH-1:0]   sel_rdata;
   logic               timeout_hit;

   bus_decoder #(
      .WIDTH      (WIDTH),
      .NSLAVE     (NSLAVE),
      .REGIONBITS (REGIONBITS),
      .SELBITS    (SELBITS)
   ) u_decoder (
      .maddr  (maddr),
      .idx    (dec_idx),
      .mapped (dec_mapped)
   );

   assign local_addr = WIDTH'(maddr[REGIONBITS-1:0]);

   generate
      for (genvar gi = 0; gi < NSLAVE; gi++) begin : g_slave
         assign srdata_arr[gi] = srdata[gi*WIDTH +: WIDTH];
         assign dec_onehot[gi] = (dec_idx == SELBITS'(gi));
      end
   endgenerate

   // Look only at the slave captured for the current transfer.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (idx_q == SELBITS'(i)) begin
            sel_ready = sready[i];
            sel_rdata = srdata_arr[i];
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int WAITBITS = $clog2(TIMEOUT);

   logic [WAITBITS-1:0] wait_q, wait_d;

   assign timeout_hit = (wait_q == WAITBITS'(TIMEOUT - 1));

   // Wait counter runs only in ACCESS and is zero on every entry to it.
   always_comb begin
      wait_d = '0;
      if (state_q == ACCESS) begin
         wait_d = wait_q + WAITBITS'(1);
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and output logic; response fields default to zero so they
   // are only non-zero during the single RESP cycle.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      sreq_d     = sreq_q;
      swrite_d   = swrite_q;
      saddr_d    = saddr_q;
      swdata_d   = swdata_q;
      mrdata_d   = '0;
      mready_d   = 1'b0;
      merr_d     = 1'b0;
      errcount_d = errcount_q;

      case (state_q)
         IDLE: begin
            if (mreq) begin
               if (dec_mapped) begin
                  state_d  = ACCESS;
                  idx_d    = dec_idx;
                  sreq_d   = dec_onehot;
                  saddr_d  = local_addr;
                  swdata_d = mwdata;
                  swrite_d = mwrite;
               end else begin
                  state_d    = RESP;
                  mready_d   = 1'b1;
                  merr_d     = 1'b1;
                  mrdata_d   = ERRDATA;
                  errcount_d = (errcount_q == 8'hFF) ? 8'hFF : errcount_q + 8'd1;
               end
            end
         end
         ACCESS: begin
            // A ready slave wins over a simultaneous timeout.
            if (sel_ready) begin
               state_d  = RESP;
               sreq_d   = '0;
               mready_d = 1'b1;
               mrdata_d = swrite_q ? '0 : sel_rdata;
            end else if (timeout_hit) begin
               state_d    = RESP;
               sreq_d     = '0;
               mready_d   = 1'b1;
               merr_d     = 1'b1;
               mrdata_d   = ERRDATA;
               errcount_d = (errcount_q == 8'hFF) ? 8'hFF : errcount_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            sreq_d  = '0;
         end
      endcase
   end

   // State and output registers; reset drops every output immediately.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         sreq_q     <= '0;
         swrite_q   <= 1'b0;
         saddr_q    <= '0;
         swdata_q   <= '0;
         mrdata_q   <= '0;
         mready_q   <= 1'b0;
         merr_q     <= 1'b0;
         errcount_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         sreq_q     <= sreq_d;
         swrite_q   <= swrite_d;
         saddr_q    <= saddr_d;
         swdata_q   <= swdata_d;
         mrdata_q   <= mrdata_d;
         mready_q   <= mready_d;
         merr_q     <= merr_d;
         errcount_q <= errcount_d;
      end
   end

   assign mrdata   = mrdata_q;
   assign mready   = mready_q;
   assign merr     = merr_q;
   assign sreq     = sreq_q;
   assign swrite   = swrite_q;
   assign saddr    = saddr_q;
   assign swdata   = swdata_q;
   assign errcount = errcount_q;

endmodule
